// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives PLL reset, debounces lock, and releases channel resets in a staggered order.
// Optional loss counter output is enabled by defining PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN.
module pll_lock_supervisor #(
    parameter int NUM_CH         = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_CYCLES    = 1024,
    parameter int RST_STAGGER    = 4,
    parameter int RETRY_W        = 4
) (
    input  logic               clock_in,
    input  logic               resetb,
    input  logic               locked,
    input  logic               clear_lost,
    output logic               pll_resetb,
    output logic [NUM_CH-1:0]  ch_rst_n,
    output logic               ready,
    output logic [2:0]         state,
    output logic [RETRY_W-1:0] retry_cnt,
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
    output logic [7:0]         loss_cnt,
`endif
    output logic               lost
);

    localparam int M_A     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int M_B     = (LOCK_CYCLES > NUM_CH * RST_STAGGER) ? LOCK_CYCLES : NUM_CH * RST_STAGGER;
    localparam int CNT_MAX = (M_A > M_B) ? M_A : M_B;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((NUM_CH - 1) * RST_STAGGER);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        DEBOUNCE  = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } st_t;

    st_t                    st;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [NUM_CH-1:0]      rel_mask;
    logic                   loss_run;

    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end

    assign lock_s   = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = cnt + 1'b1;
    assign state    = st;
    assign loss_run = (st == RUN) && !lock_s;

    // Channels whose release slot has been reached by the next RELEASE cycle; monotone, so bits never drop.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_rel
        assign rel_mask[i] = (32'(cnt_inc) >= 32'(i * RST_STAGGER));
    end

    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            st         <= PLL_RST;
            cnt        <= '0;
            pll_resetb <= 1'b0;
            ch_rst_n   <= '0;
            ready      <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            case (st)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        st         <= WAIT_LOCK;
                        cnt        <= '0;
                        pll_resetb <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        st  <= DEBOUNCE;
                        cnt <= '0;
                    end else if (cnt == TO_LAST) begin
                        st         <= PLL_RST;
                        cnt        <= '0;
                        pll_resetb <= 1'b0;
                        if (retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DEBOUNCE: begin
                    if (!lock_s) begin
                        st  <= WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        st       <= RELEASE;
                        cnt      <= '0;
                        ch_rst_n <= NUM_CH'(1);
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        st         <= PLL_RST;
                        cnt        <= '0;
                        pll_resetb <= 1'b0;
                        ch_rst_n   <= '0;
                        ready      <= 1'b0;
                    end else if (cnt == REL_LAST) begin
                        st    <= RUN;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt      <= cnt_inc;
                        ch_rst_n <= rel_mask;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        st         <= PLL_RST;
                        cnt        <= '0;
                        pll_resetb <= 1'b0;
                        ch_rst_n   <= '0;
                        ready      <= 1'b0;
                    end
                end
                default: begin
                    st         <= PLL_RST;
                    cnt        <= '0;
                    pll_resetb <= 1'b0;
                    ch_rst_n   <= '0;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    // Set wins over clear so a loss coinciding with clear_lost is never missed.
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb)         lost <= 1'b0;
        else if (loss_run)   lost <= 1'b1;
        else if (clear_lost) lost <= 1'b0;
    end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb)                           loss_cnt <= '0;
        else if (clear_lost)                   loss_cnt <= {7'd0, loss_run};
        else if (loss_run && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expected output snapshots are queued with their cycle stamp
// and a monitor pops one on every observed output change.
module tb_pll_lock_supervisor;

    logic       clock_in = 1'b0;
    logic       resetb = 1'b0;
    logic       locked = 1'b1;
    logic       clear_lost = 1'b0;
    logic       pll_resetb;
    logic [2:0] ch_rst_n;
    logic       ready;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic       lost;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
    logic [7:0] loss_cnt;
`endif

    pll_lock_supervisor #(
        .NUM_CH(3), .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32),
        .LOCK_CYCLES(8), .RST_STAGGER(3), .RETRY_W(4)
    ) dut (
        .clock_in(clock_in), .resetb(resetb), .locked(locked), .clear_lost(clear_lost),
        .pll_resetb(pll_resetb), .ch_rst_n(ch_rst_n), .ready(ready), .state(state),
        .retry_cnt(retry_cnt),
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
        .loss_cnt(loss_cnt),
`endif
        .lost(lost)
    );

    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [12:0] v;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    logic [12:0] prev;
    logic [12:0] snap;

    assign snap = {pll_resetb, ch_rst_n, ready, state, retry_cnt, lost};

    function automatic logic [12:0] mk(logic pr, logic [2:0] ch, logic rdy, logic [2:0] st,
                                       logic [3:0] rt, logic lst);
        return {pr, ch, rdy, st, rt, lst};
    endfunction

    task automatic push(int c, logic [12:0] v);
        exp_t x;
        x.c = c;
        x.v = v;
        q.push_back(x);
    endtask

    // Clean lock sequence starting from PLL_RST entry at cycle b with lock_s already high.
    task automatic seq(int b, logic [3:0] rt, logic lst);
        push(b + 4,  mk(1, 3'b000, 0, 3'd1, rt, lst));
        push(b + 5,  mk(1, 3'b000, 0, 3'd2, rt, lst));
        push(b + 13, mk(1, 3'b001, 0, 3'd3, rt, lst));
        push(b + 16, mk(1, 3'b011, 0, 3'd3, rt, lst));
        push(b + 19, mk(1, 3'b111, 0, 3'd3, rt, lst));
        push(b + 20, mk(1, 3'b111, 1, 3'd4, rt, lst));
    endtask

    task automatic chk(string nm, logic [12:0] got, logic [12:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic at(int c);
        while (cyc < c) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    always @(negedge clock_in) begin
        if (!mon_en) begin
            prev = snap;
        end else if (snap !== prev) begin
            prev = snap;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change cyc=%0d got=%b", cyc, snap);
            end else begin
                e = q.pop_front();
                if (e.v !== snap || e.c != cyc) begin
                    bad++;
                    $display("FAIL out_trace got cyc=%0d val=%b want cyc=%0d val=%b",
                             cyc, snap, e.c, e.v);
                end
            end
        end
    end

    initial begin
        int b, c1, c2, k;
        resetb = 1'b0; locked = 1'b1; clear_lost = 1'b0;
        repeat (2) @(posedge clock_in);
        #1;
        chk("reset_init", snap, mk(0, 3'b000, 0, 3'd0, 4'd0, 0));

        // clean lock
        mon_en = 1'b1;
        b = cyc;
        resetb = 1'b1;
        seq(b, 4'd0, 1'b0);

        // loss in RUN, re-lock, then clear lost
        c1 = b + 25;
        at(c1);
        locked = 1'b0;
        push(c1 + 3, mk(0, 3'b000, 0, 3'd0, 4'd0, 1));
        seq(c1 + 3, 4'd0, 1'b1);
        at(c1 + 3);
        locked = 1'b1;
        c2 = c1 + 29;
        at(c2);
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
        chk("loss_cnt_after_loss", 13'(loss_cnt), 13'd1);
`endif
        clear_lost = 1'b1;
        push(c2 + 1, mk(1, 3'b111, 1, 3'd4, 4'd0, 0));
        at(c2 + 1);
        clear_lost = 1'b0;

        // async reset in RUN, then timeout retries
        k = c2 + 4;
        at(k);
        resetb = 1'b0;
        locked = 1'b0;
        push(k, mk(0, 3'b000, 0, 3'd0, 4'd0, 0));
        #1;
        chk("async_reset_b", snap, mk(0, 3'b000, 0, 3'd0, 4'd0, 0));
        at(k + 1);
        resetb = 1'b1;
        b = k + 1;
        push(b + 4,   mk(1, 3'b000, 0, 3'd1, 4'd0, 0));
        push(b + 36,  mk(0, 3'b000, 0, 3'd0, 4'd1, 0));
        push(b + 40,  mk(1, 3'b000, 0, 3'd1, 4'd1, 0));
        push(b + 72,  mk(0, 3'b000, 0, 3'd0, 4'd2, 0));
        push(b + 76,  mk(1, 3'b000, 0, 3'd1, 4'd2, 0));
        push(b + 108, mk(0, 3'b000, 0, 3'd0, 4'd3, 0));
        seq(b + 108, 4'd3, 1'b0);
        at(b + 108);
        locked = 1'b1;

        // async reset in RUN with retry_cnt=3 must clear immediately
        k = b + 133;
        at(k);
        resetb = 1'b0;
        locked = 1'b0;
        push(k, mk(0, 3'b000, 0, 3'd0, 4'd0, 0));
        #1;
        chk("async_reset_run", snap, mk(0, 3'b000, 0, 3'd0, 4'd0, 0));
        at(k + 1);
        resetb = 1'b1;
        b = k + 1;

        // debounce glitch, then loss during RELEASE
        push(b + 4,  mk(1, 3'b000, 0, 3'd1, 4'd0, 0));
        push(b + 8,  mk(1, 3'b000, 0, 3'd2, 4'd0, 0));
        push(b + 13, mk(1, 3'b000, 0, 3'd1, 4'd0, 0));
        push(b + 14, mk(1, 3'b000, 0, 3'd2, 4'd0, 0));
        push(b + 22, mk(1, 3'b001, 0, 3'd3, 4'd0, 0));
        push(b + 25, mk(1, 3'b011, 0, 3'd3, 4'd0, 0));
        push(b + 28, mk(0, 3'b000, 0, 3'd0, 4'd0, 0));
        push(b + 32, mk(1, 3'b000, 0, 3'd1, 4'd0, 0));
        at(b + 5);
        locked = 1'b1;
        at(b + 10);
        locked = 1'b0;
        at(b + 11);
        locked = 1'b1;
        at(b + 25);
        locked = 1'b0;
        at(b + 40);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_expect got=%0d left want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
